mac_sequencer: RTL and testbench
================================

// Module: mac_sequencer
// PURPOSE
//  Controller for the mac datapath. Holds one DEPTH-entry vector of x
//  operands and one of w operands, loaded over a simple write port.
//  On start, it streams the pairs into mac with data_en/x/w, waits for the
//  pipeline to drain, and captures mac's y output as the result.
//  Sits between the UART command path and mac_i, on clk_100m.
// PARAMETERS
//  DEPTH    6  number of x/w pairs per run (1..8)
//  DW       8  width of each x and w operand
//  YW       5  width of the mac result y
//  MAC_LAT  2  cycles from the last data_en beat to a valid y (0..15)
// PORTS
//  clk      in   1         system clock (clk_100m)
//  rst      in   1         asynchronous reset, active-high
//  wr_en    in   1         operand write strobe
//  wr_sel   in   1         0 = write the x vector, 1 = write the w vector
//  wr_addr  in   3         operand index; must be < DEPTH
//  wr_data  in   DW        operand value
//  start    in   1         run request (level, sampled only in IDLE)
//  busy     out  1         high in every non-IDLE state
//  done     out  1         1-cycle pulse; result valid this cycle
//  result   out  YW        y captured at end of last run (held)
//  wr_err   out  1         1-cycle pulse: write dropped (busy or bad addr)
//  mac_en   out  1         data_en to mac
//  mac_x    out  DW        x operand to mac
//  mac_w    out  DW        w operand to mac
//  mac_clr  out  1         accumulator clear to mac (see CONFIGURATION)
//  mac_y    in   YW        y from mac
// BEHAVIOUR
//  - Reset is async. All outputs = 0. State = IDLE. Both operand arrays are
//    cleared to 0. If rst asserts mid-run, the run is aborted: no done pulse,
//    and result returns to 0.
//  - All outputs are registered. No combinational path from inputs to outputs.
//  - Writes are accepted only in IDLE with wr_addr < DEPTH. The write lands
//    at the clock edge.
//  - A write while busy, or with wr_addr >= DEPTH, is dropped, the array is
//    unchanged, and wr_err pulses on the next cycle.
//  - If wr_en and start are sampled on the same edge in IDLE, the write
//    lands first and the run uses the new value.
//  - FSM states:
//    - IDLE: go to CLEAR (macro on) or FEED when start = 1.
//    - CLEAR: 1 cycle with mac_clr = 1, then go to FEED.
//    - FEED: exactly DEPTH cycles. mac_en = 1. mac_x/mac_w present entry
//      idx = 0..DEPTH-1 in order. idx counter wraps to 0 on exit.
//    - WAIT: exactly MAC_LAT cycles with mac_en = 0. Skipped if MAC_LAT = 0.
//    - DONE: 1 cycle with done = 1. result <= mac_y at the edge entering
//      DONE. Then go to IDLE.
//  - In non-FEED states, mac_en = 0 and mac_x = mac_w = 0.
//  - start is ignored while busy. No queueing. A start held high re-runs on
//    the first IDLE cycle after DONE (one IDLE cycle between runs).
//  - Timing, with the start-accepting edge as cycle 0 and the macro off:
//    - mac_en is high in cycles 1..DEPTH.
//    - done is high in cycle DEPTH+MAC_LAT+1.
//    - busy is high in cycles 1..DEPTH+MAC_LAT+1.
//    - Enabling the macro adds 1 cycle to each of these.
//  - result holds its value until the next DONE or reset. Operand arrays are
//    preserved across runs.
// CONFIGURATION
//  MAC_SEQ_CLR_EN
//  - Defined: the CLEAR state exists and mac_clr pulses once per run, in
//    cycle 1.
//  - Undefined: CLEAR is removed, IDLE goes straight to FEED, and mac_clr is
//    tied 0.
// TESTING
//  1 Reset: x=1..6, w=2 (DEPTH=6, MAC_LAT=2, macro off), start 1 cycle.
//    Expect mac_en high in cycles 1..6 with x=1,2,3,4,5,6 and w=2.
//    Expect done in cycle 9 with busy high in cycles 1..9. Model mac_y=5'd21:
//    result=21.
//  2 Write at wr_addr=6: wr_err pulses, arrays unchanged.
//    Write during FEED: wr_err pulses, the run's mac_x sequence unchanged.
//  3 start held high for 3 runs: done in cycles 9, 19, 29.
//    Pulsing start in cycle 4 has no effect.
//  4 Same-edge wr_en(x[0]=0x7F) and start: first beat has mac_x=0x7F.
//  5 rst pulse in cycle 5 of a run: all outputs 0 asynchronously, no done,
//    result=0. Arrays read 0 on the next run.
//  6 With MAC_SEQ_CLR_EN: mac_clr=1 in cycle 1 only, mac_en in cycles 2..7,
//    done in cycle 10. MAC_LAT=0: done in cycle DEPTH+1 (+1 with the macro).

Source files
------------

// File: rtl/mac_sequencer_if.sv
// Operand-load, run-control and mac datapath signals of mac_sequencer.
// The slave side is the sequencer. The master side is the command path and the mac model.
`timescale 1ns/1ps
interface mac_sequencer_if #(
    parameter int DW = 8,
    parameter int YW = 5
);
    logic          wr_en;
    logic          wr_sel;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [YW-1:0] result;
    logic          wr_err;
    logic          mac_en;
    logic [DW-1:0] mac_x;
    logic [DW-1:0] mac_w;
    logic          mac_clr;
    logic [YW-1:0] mac_y;

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, mac_y,
        output busy, done, result, wr_err, mac_en, mac_x, mac_w, mac_clr
    );

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, mac_y,
        input  busy, done, result, wr_err, mac_en, mac_x, mac_w, mac_clr
    );
endinterface

// File: rtl/mac_sequencer.sv
// Loads x/w operand vectors and streams them into mac on start. It then waits MAC_LAT cycles and captures y.
// All outputs are registered. The optional CLEAR state is enabled by the macro MAC_SEQ_CLR_EN.
`timescale 1ns/1ps
module mac_sequencer #(
    parameter int DEPTH   = 6,
    parameter int DW      = 8,
    parameter int YW      = 5,
    parameter int MAC_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    mac_sequencer_if.slave     bus
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] DEPTH_W  = 4'(DEPTH);
    localparam logic [2:0] IDX_LAST = 3'(DEPTH - 1);
    localparam logic [3:0] LAT_LAST = (MAC_LAT == 0) ? 4'd0 : 4'(MAC_LAT - 1);

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [DW-1:0] x_q [DEPTH];
    logic [DW-1:0] x_d [DEPTH];
    logic [DW-1:0] w_q [DEPTH];
    logic [DW-1:0] w_d [DEPTH];
    logic          busy_q, done_q, wr_err_q, mac_en_q;
    logic [DW-1:0] mac_x_q, mac_w_q;
    logic [YW-1:0] result_q;
    logic          wr_ok;
    logic          feed_d;

    assign wr_ok  = bus.wr_en && (state_q == S_IDLE) && ({1'b0, bus.wr_addr} < DEPTH_W);
    assign feed_d = (state_d == S_FEED);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        x_d     = x_q;
        w_d     = w_q;
        // The write is folded into the next-state arrays so a same-edge start sees it.
        if (wr_ok) begin
            if (bus.wr_sel) w_d[bus.wr_addr] = bus.wr_data;
            else            x_d[bus.wr_addr] = bus.wr_data;
        end
        case (state_q)
            S_IDLE: begin
                idx_d = 3'd0;
                if (bus.start) begin
`ifdef MAC_SEQ_CLR_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_FEED;
`endif
                end
            end
            S_CLEAR: state_d = S_FEED;
            S_FEED: begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = 3'd0;
                    wcnt_d  = 4'd0;
                    state_d = (MAC_LAT == 0) ? S_DONE : S_WAIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (wcnt_q == LAT_LAST) state_d = S_DONE;
                else                    wcnt_d  = wcnt_q + 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            wcnt_q   <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            mac_en_q <= 1'b0;
            mac_x_q  <= '0;
            mac_w_q  <= '0;
            result_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wcnt_q   <= wcnt_d;
            x_q      <= x_d;
            w_q      <= w_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
            wr_err_q <= bus.wr_en && !wr_ok;
            mac_en_q <= feed_d;
            mac_x_q  <= feed_d ? x_d[idx_d] : '0;
            mac_w_q  <= feed_d ? w_d[idx_d] : '0;
            if (state_d == S_DONE) result_q <= bus.mac_y;
        end
    end

`ifdef MAC_SEQ_CLR_EN
    logic mac_clr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mac_clr_q <= 1'b0;
        else     mac_clr_q <= (state_d == S_CLEAR);
    end
    assign bus.mac_clr = mac_clr_q;
`else
    assign bus.mac_clr = 1'b0;
`endif

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.wr_err = wr_err_q;
    assign bus.mac_en = mac_en_q;
    assign bus.mac_x  = mac_x_q;
    assign bus.mac_w  = mac_w_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed and randomized bench for mac_sequencer.
// A second instance with MAC_LAT=0 is checked for the shortened done timing.
`timescale 1ns/1ps
module tb_mac_sequencer;
    localparam int DEPTH = 6;
    localparam int DW    = 8;
    localparam int YW    = 5;
    localparam int LAT   = 2;
`ifdef MAC_SEQ_CLR_EN
    localparam int O = 1;
`else
    localparam int O = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_sequencer_if #(.DW(DW), .YW(YW)) bus ();
    mac_sequencer_if #(.DW(DW), .YW(YW)) bus0 ();

    assign bus0.wr_en   = bus.wr_en;
    assign bus0.wr_sel  = bus.wr_sel;
    assign bus0.wr_addr = bus.wr_addr;
    assign bus0.wr_data = bus.wr_data;
    assign bus0.start   = bus.start;
    assign bus0.mac_y   = bus.mac_y;

    mac_sequencer #(.DEPTH(DEPTH), .DW(DW), .YW(YW), .MAC_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    mac_sequencer #(.DEPTH(DEPTH), .DW(DW), .YW(YW), .MAC_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));

    int errs   = 0;
    int checks = 0;
    logic [DW-1:0] mx [DEPTH];
    logic [DW-1:0] mw [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic [YW-1:0] res);
        chk(tag, {bus.busy, bus.done, bus.mac_en, bus.mac_clr, bus.wr_err, bus.mac_x, bus.mac_w, bus.result},
            {5'b0, 16'h0, res});
    endtask

    // Writes are only issued here while the sequencer is idle, so acceptance depends on the address alone.
    task automatic wr(input bit sel, input int addr, input logic [DW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 3'(addr);
        bus.wr_data = data;
        if (addr < DEPTH) begin
            if (sel) mw[addr] = data;
            else     mx[addr] = data;
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk($sformatf("wr_err sel%0d addr%0d", sel, addr), 32'(bus.wr_err), 32'(addr >= DEPTH));
    endtask

    // Entered at the negedge of cycle 0 with the sequencer idle; returns at the negedge of the first idle cycle.
    task automatic run(input bit hold, input int sp, input int wc, input bit sw,
                       input logic [DW-1:0] swd, input logic [YW-1:0] y, input bit chk0, input string tag);
        int n;
        int n0;
        bit en;
        n  = DEPTH + LAT + 1 + O;
        n0 = DEPTH + 1 + O;
        bus.mac_y = y;
        bus.start = 1'b1;
        if (sw) begin
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = swd;
            mx[0] = swd;
        end
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            en = (c > O) && (c <= O + DEPTH);
            chk({tag, " busy"},   32'(bus.busy),    32'd1);
            chk({tag, " done"},   32'(bus.done),    32'(c == n));
            chk({tag, " mac_en"}, 32'(bus.mac_en),  32'(en));
            chk({tag, " mac_x"},  32'(bus.mac_x),   en ? 32'(mx[c-O-1]) : 32'd0);
            chk({tag, " mac_w"},  32'(bus.mac_w),   en ? 32'(mw[c-O-1]) : 32'd0);
            chk({tag, " mac_clr"},32'(bus.mac_clr), 32'((O == 1) && (c == 1)));
            chk({tag, " wr_err"}, 32'(bus.wr_err),  32'((wc != 0) && (c == wc + 1)));
            if (c == n) chk({tag, " result"}, 32'(bus.result), 32'(y));
            if (chk0) begin
                chk({tag, " lat0 done"}, 32'(bus0.done), 32'(c == n0));
                chk({tag, " lat0 busy"}, 32'(bus0.busy), 32'(c <= n0));
            end
            if (c == 1) begin
                bus.wr_en = 1'b0;
                if (!hold) bus.start = 1'b0;
            end
            if (c == wc) begin
                bus.wr_en = 1'b1; bus.wr_sel = 1'($urandom_range(0, 1));
                bus.wr_addr = 3'd0; bus.wr_data = 8'hA5;
            end else if (c == wc + 1) begin
                bus.wr_en = 1'b0;
            end
            if (c == sp)                     bus.start = 1'b1;
            else if (c == sp + 1 && !hold)   bus.start = 1'b0;
        end
        @(negedge clk);
        chk({tag, " end busy/done"}, {30'd0, bus.busy, bus.done}, 32'd0);
        chk({tag, " end result"},    32'(bus.result), 32'(y));
    endtask

    initial begin
        logic [YW-1:0] y;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = '0;
        bus.start = 1'b0; bus.mac_y = '0;
        for (int i = 0; i < DEPTH; i++) begin mx[i] = '0; mw[i] = '0; end

        repeat (2) @(negedge clk);
        chk_quiet("reset outputs", '0);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("idle after reset", '0);

        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b0, i, 8'(i + 1));
            wr(1'b1, i, 8'd2);
        end
        run(1'b0, 0, 0, 1'b0, '0, 5'd21, 1'b1, "t1");

        wr(1'b0, 6, 8'hEE);
        wr(1'b1, 7, 8'hEE);
        run(1'b0, 0, 3, 1'b0, '0, 5'd13, 1'b0, "t2 bad addr/feed write");

        run(1'b1, 0, 0, 1'b0, '0, 5'd7,  1'b0, "t3 run1");
        run(1'b1, 0, 0, 1'b0, '0, 5'd9,  1'b0, "t3 run2");
        run(1'b0, 0, 0, 1'b0, '0, 5'd11, 1'b0, "t3 run3");
        run(1'b0, 4, 0, 1'b0, '0, 5'd3,  1'b0, "t3 start pulse");
        @(negedge clk);
        chk("start pulse ignored", {30'd0, bus.busy, bus.done}, 32'd0);

        run(1'b0, 0, 0, 1'b1, 8'h7F, 5'd17, 1'b0, "t4 same-edge write");

        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk_quiet("t5 async reset", '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin mx[i] = '0; mw[i] = '0; end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("t5 no done after abort", {bus.busy, bus.done, 27'd0, bus.result}, 32'd0);
        end
        run(1'b0, 0, 0, 1'b0, '0, 5'd25, 1'b0, "t5 cleared arrays");

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wr(1'b0, i, 8'($urandom));
                wr(1'b1, i, 8'($urandom));
            end
            y = 5'($urandom_range(1, 31));
            run(1'b0, 0, $urandom_range(1, DEPTH), 1'b0, '0, y, 1'b0, $sformatf("rand%0d", k));
        end

        repeat (10) @(negedge clk);
        run(1'b0, 0, 0, 1'b0, '0, 5'd30, 1'b1, "t6 lat0");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
